// File: rtl/result_display_driver_if.sv
// Bundle between the calculator core / display hardware and result_display_driver.
// The master side produces Result/Overflow and consumes the display outputs.
interface result_display_driver_if #(
    parameter int W      = 11,
    parameter int DIGITS = 3
) ();
    logic [W-1:0]          Result;
    logic                  Overflow;
    logic [7*DIGITS-1:0]   DigitSeg;
    logic [6:0]            SignSeg;
    logic                  CantDisplay;
    logic                  Busy;

    modport master (
        output Result, Overflow,
        input  DigitSeg, SignSeg, CantDisplay, Busy
    );

    modport slave (
        input  Result, Overflow,
        output DigitSeg, SignSeg, CantDisplay, Busy
    );
endinterface

// File: rtl/result_display_driver.sv
// Converts the calculator's signed result to BCD with a sequential double-dabble engine
// and drives active-low seven-segment digits, a sign display and a can't-display flag.
module result_display_driver #(
    parameter int W      = 11,
    parameter int DIGITS = 3
) (
    input logic                    Clock,
    input logic                    Reset,
    result_display_driver_if.slave bus
);
    // ceil(W*log10(2)) nibbles hold any W-bit magnitude exactly
    localparam int BCDN = (W * 30103 + 99999) / 100000;
    localparam int NIB  = (BCDN > DIGITS) ? BCDN : DIGITS;
    localparam int CW   = $clog2(W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]          state;
    logic                pending;
    logic [W-1:0]        snapshot;
    logic                snapovf;
    logic [W-1:0]        lastresult;
    logic                lastovf;
    logic [W-1:0]        mag;
    logic [4*NIB-1:0]    bcd;
    logic [4*NIB-1:0]    bcdadj;
    logic [CW-1:0]       bitcnt;
    logic [7*DIGITS-1:0] digitnext;
    logic [6:0]          signnext;
    logic                cantnext;
    logic                toobig;
    logic                seen;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        bcdadj = bcd;
        for (int i = 0; i < NIB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcdadj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digits are scanned from the most significant one down so leading zeros blank
    always_comb begin
        toobig    = 1'b0;
        seen      = 1'b0;
        digitnext = '1;
        signnext  = SEG_BLANK;
        cantnext  = 1'b0;
        for (int i = DIGITS; i < NIB; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                toobig = 1'b1;
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0)
                seen = 1'b1;
            if (seen || i == 0)
                digitnext[7*i +: 7] = seg7(bcd[4*i +: 4]);
            else
                digitnext[7*i +: 7] = SEG_BLANK;
        end
        if (snapovf || toobig) begin
            digitnext = {DIGITS{SEG_DASH}};
            cantnext  = 1'b1;
        end else if (snapshot[W-1]) begin
            signnext = SEG_DASH;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= IDLE;
            pending         <= 1'b1;
            snapshot        <= '0;
            snapovf         <= 1'b0;
            lastresult      <= '0;
            lastovf         <= 1'b0;
            mag             <= '0;
            bcd             <= '0;
            bitcnt          <= '0;
            bus.DigitSeg    <= '1;
            bus.SignSeg     <= SEG_BLANK;
            bus.CantDisplay <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending || {bus.Result, bus.Overflow} != {lastresult, lastovf}) begin
                        snapshot <= bus.Result;
                        snapovf  <= bus.Overflow;
                        pending  <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Negating -2^(W-1) wraps to itself, which read unsigned is 2^(W-1)
                    mag    <= snapshot[W-1] ? -snapshot : snapshot;
                    bcd    <= '0;
                    bitcnt <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {bcd, mag} <= {bcdadj, mag} << 1;
                    bitcnt     <= bitcnt + CW'(1);
                    if (bitcnt == CW'(W - 1))
                        state <= DONE;
                end
                default: begin
                    bus.DigitSeg    <= digitnext;
                    bus.SignSeg     <= signnext;
                    bus.CantDisplay <= cantnext;
                    lastresult      <= snapshot;
                    lastovf         <= snapovf;
                    state           <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
endmodule

// File: tb/tb_result_display_driver.sv
// Self-checking bench for result_display_driver: directed vector table, multi-cycle
// corner sequences and randomized values checked against an arithmetic display model.
module tb_result_display_driver;
    localparam int W      = 11;
    localparam int DIGITS = 3;
    localparam int LAT    = W + 3;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    typedef struct {
        int         r;
        bit         o;
        logic [20:0] dig;
        logic [6:0]  sg;
        bit         cant;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [6:0]  enc [0:9];
    logic [20:0] curDig;
    logic [6:0]  curSign;
    logic        curCant;
    vec_t        vecs [7];

    result_display_driver_if #(.W(W), .DIGITS(DIGITS)) bus ();

    result_display_driver #(.W(W), .DIGITS(DIGITS)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Display expected for a value, computed with decimal arithmetic
    function automatic void model(input int r, input bit o, output logic [20:0] dig,
                                  output logic [6:0] sg, output logic cant);
        int m;
        m = (r < 0) ? -r : r;
        if (o || m > 999) begin
            dig  = {DS, DS, DS};
            sg   = BL;
            cant = 1'b1;
        end else begin
            dig[6:0]   = enc[m % 10];
            dig[13:7]  = (m >= 10)  ? enc[(m / 10) % 10] : BL;
            dig[20:14] = (m >= 100) ? enc[m / 100] : BL;
            sg         = (r < 0) ? DS : BL;
            cant       = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input int r, input bit o);
        bus.Result   = 11'(r);
        bus.Overflow = o;
    endtask

    task automatic checkOutput(input string name, input int k, input logic eBusy,
                               input logic [20:0] eDig, input logic [6:0] eSign,
                               input logic eCant);
        tests++;
        if (bus.Busy !== eBusy || bus.DigitSeg !== eDig || bus.SignSeg !== eSign ||
            bus.CantDisplay !== eCant) begin
            fails++;
            $display("[TB] FAIL %s edge %0d: got busy=%b dig=%b sign=%b cant=%b, want busy=%b dig=%b sign=%b cant=%b",
                     name, k, bus.Busy, bus.DigitSeg, bus.SignSeg, bus.CantDisplay,
                     eBusy, eDig, eSign, eCant);
        end
    endtask

    // Old display must hold while Busy, new display lands on the LAT-th edge with Busy low
    task automatic convert(input string name, input int r, input bit o,
                           input logic [20:0] eDig, input logic [6:0] eSign, input logic eCant);
        applyStimulus(r, o);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT)
                checkOutput(name, k, 1'b1, curDig, curSign, curCant);
            else
                checkOutput(name, k, 1'b0, eDig, eSign, eCant);
        end
        curDig  = eDig;
        curSign = eSign;
        curCant = eCant;
    endtask

    initial begin
        int          lastR;
        bit          lastO;
        int          r;
        bit          o;
        logic [20:0] mDig;
        logic [6:0]  mSign;
        logic        mCant;

        enc = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
        vecs[0] = '{r: 18,    o: 1'b0, dig: {BL, S1, S8}, sg: BL, cant: 1'b0};
        vecs[1] = '{r: -205,  o: 1'b0, dig: {S2, S0, S5}, sg: DS, cant: 1'b0};
        vecs[2] = '{r: 0,     o: 1'b0, dig: {BL, BL, S0}, sg: BL, cant: 1'b0};
        vecs[3] = '{r: 1000,  o: 1'b0, dig: {DS, DS, DS}, sg: BL, cant: 1'b1};
        vecs[4] = '{r: -1024, o: 1'b0, dig: {DS, DS, DS}, sg: BL, cant: 1'b1};
        vecs[5] = '{r: 5,     o: 1'b1, dig: {DS, DS, DS}, sg: BL, cant: 1'b1};
        vecs[6] = '{r: 999,   o: 1'b0, dig: {S9, S9, S9}, sg: BL, cant: 1'b0};

        applyStimulus(6, 1'b0);
        tick();
        tick();
        curDig  = '1;
        curSign = BL;
        curCant = 1'b0;
        checkOutput("reset", 0, 1'b0, curDig, curSign, curCant);
        Reset = 1'b0;
        convert("first6", 6, 1'b0, {BL, BL, S6}, BL, 1'b0);

        for (int i = 0; i < 7; i++)
            convert($sformatf("vec%0d", i), vecs[i].r, vecs[i].o, vecs[i].dig, vecs[i].sg,
                    vecs[i].cant);

        // Result changes 3 cycles into SHIFT: '12' completes, then '34' follows
        applyStimulus(12, 1'b0);
        for (int k = 1; k <= 2 * LAT; k++) begin
            tick();
            if (k == 5)
                applyStimulus(34, 1'b0);
            if (k < LAT)
                checkOutput("midchange", k, 1'b1, curDig, curSign, curCant);
            else if (k == LAT)
                checkOutput("midchange", k, 1'b0, {BL, S1, S2}, BL, 1'b0);
            else if (k < 2 * LAT)
                checkOutput("midchange", k, 1'b1, {BL, S1, S2}, BL, 1'b0);
            else
                checkOutput("midchange", k, 1'b0, {BL, S3, S4}, BL, 1'b0);
        end
        curDig = {BL, S3, S4};

        // Reset during SHIFT abandons the conversion; it restarts once released
        applyStimulus(77, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("rstmid", k, 1'b1, curDig, curSign, curCant);
        end
        Reset = 1'b1;
        tick();
        curDig  = '1;
        curSign = BL;
        curCant = 1'b0;
        checkOutput("rstblank", 0, 1'b0, curDig, curSign, curCant);
        Reset = 1'b0;
        convert("rstredo", 77, 1'b0, {BL, S7, S7}, BL, 1'b0);

        lastR = 77;
        lastO = 1'b0;
        for (int n = 0; n < 30; n++) begin
            do begin
                r = int'($urandom_range(0, 2047)) - 1024;
                o = ($urandom_range(0, 7) == 0);
            end while (r == lastR && o == lastO);
            model(r, o, mDig, mSign, mCant);
            convert($sformatf("rand%0d(%0d,%0b)", n, r, o), r, o, mDig, mSign, mCant);
            lastR = r;
            lastO = o;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
